// File: rtl/hazard_sched_if.sv
// Pipeline-to-hazard-controller bundle: decoded control and register indices in; stall, flush, forward and status out.
// master = pipeline side driving control, slave = hazard_sched.
interface hazard_sched_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic [1:0]       ex_wdsel;
  logic [2:0]       ex_npcop;
  logic             ex_br_taken;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic             dmem_req;
  logic             dmem_ready;

  logic             stall_pc;
  logic             stall_ifid;
  logic             stall_idex;
  logic             stall_exmem;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_memwb;
  logic             redirect;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_err;
  logic             halted;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_flush;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_regwrite, ex_wdsel, ex_npcop, ex_br_taken, mem_rd, mem_regwrite,
           wb_rd, wb_regwrite, dmem_req, dmem_ready,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
           flush_memwb, redirect, fwd_a, fwd_b, mem_err, halted, cnt_stall, cnt_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_regwrite, ex_wdsel, ex_npcop, ex_br_taken, mem_rd, mem_regwrite,
           wb_rd, wb_regwrite, dmem_req, dmem_ready,
    output stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
           flush_memwb, redirect, fwd_a, fwd_b, mem_err, halted, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/hazard_sched.sv
// RV32I 5-stage hazard controller: load-use stall, branch redirect/flush, dmem wait freeze, EX forwarding, perf counters.
// Latency: stall/flush/forward are combinational; mem_err and counters are registered. Backpressure: dmem_ready low freezes PC..EX/MEM.
module hazard_sched #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rstn,
  hazard_sched_if.slave hif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [7:0] TMO = MEM_TIMEOUT[7:0];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wcnt;
  logic [7:0]       w_wcnt_nxt;
  logic [7:0]       w_wcnt_inc;
  logic             r_mem_err;
  logic             w_mem_err_nxt;
  logic [CNT_W-1:0] r_cnt_stall;
  logic [CNT_W-1:0] r_cnt_flush;

  logic w_lu, w_br, w_mw;
  logic w_stall_pc, w_stall_ifid, w_stall_idex, w_stall_exmem;
  logic w_flush_ifid, w_flush_idex, w_flush_memwb;
  logic w_redirect, w_halted;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_lu = hif.ex_regwrite && (hif.ex_wdsel == 2'b01) && (hif.ex_rd != 5'd0) &&
                ((hif.id_use_rs1 && (hif.id_rs1 == hif.ex_rd)) ||
                 (hif.id_use_rs2 && (hif.id_rs2 == hif.ex_rd)));
  assign w_br = (hif.ex_npcop[0] & hif.ex_br_taken) | hif.ex_npcop[1] | hif.ex_npcop[2];
  assign w_mw = hif.dmem_req & ~hif.dmem_ready;
  assign w_wcnt_inc = r_wcnt + 8'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= RUN;
      r_wcnt    <= 8'd0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_mem_err <= w_mem_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_mem_err_nxt = 1'b0;
    w_stall_pc    = 1'b0;
    w_stall_ifid  = 1'b0;
    w_stall_idex  = 1'b0;
    w_stall_exmem = 1'b0;
    w_flush_ifid  = 1'b0;
    w_flush_idex  = 1'b0;
    w_flush_memwb = 1'b0;
    w_redirect    = 1'b0;
    w_halted      = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mw) begin
          // EX is held, so a coincident branch or load-use resolves once memory releases.
          {w_stall_pc, w_stall_ifid, w_stall_idex, w_stall_exmem} = 4'hF;
          w_flush_memwb = 1'b1;
          w_state_nxt   = MEM_WAIT;
          w_wcnt_nxt    = 8'd1;
        end else if (w_br) begin
          w_redirect   = 1'b1;
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
        end else if (w_lu) begin
          w_stall_pc   = 1'b1;
          w_stall_ifid = 1'b1;
          w_flush_idex = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hif.dmem_ready) begin
          w_state_nxt = RUN;
          w_wcnt_nxt  = 8'd0;
          if (w_br) begin
            w_redirect   = 1'b1;
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
          end else if (w_lu) begin
            w_stall_pc   = 1'b1;
            w_stall_ifid = 1'b1;
            w_flush_idex = 1'b1;
          end
        end else begin
          {w_stall_pc, w_stall_ifid, w_stall_idex, w_stall_exmem} = 4'hF;
          w_flush_memwb = 1'b1;
          w_wcnt_nxt    = w_wcnt_inc;
          if (w_wcnt_inc == TMO) begin
            w_mem_err_nxt = 1'b1;
            w_state_nxt   = HALT;
          end
        end
      end
      HALT: begin
        {w_stall_pc, w_stall_ifid, w_stall_idex, w_stall_exmem} = 4'hF;
        w_flush_memwb = 1'b1;
        w_halted      = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // MEM beats WB because it holds the younger write to the same register.
  always_comb begin
    w_fwd_a = 2'b00;
    if (hif.mem_regwrite && (hif.mem_rd != 5'd0) && (hif.mem_rd == hif.ex_rs1))
      w_fwd_a = 2'b01;
    else if (hif.wb_regwrite && (hif.wb_rd != 5'd0) && (hif.wb_rd == hif.ex_rs1))
      w_fwd_a = 2'b10;
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (hif.mem_regwrite && (hif.mem_rd != 5'd0) && (hif.mem_rd == hif.ex_rs2))
      w_fwd_b = 2'b01;
    else if (hif.wb_regwrite && (hif.wb_rd != 5'd0) && (hif.wb_rd == hif.ex_rs2))
      w_fwd_b = 2'b10;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt_stall <= '0;
      r_cnt_flush <= '0;
    end else begin
      if (w_stall_pc && (r_cnt_stall != {CNT_W{1'b1}}))
        r_cnt_stall <= r_cnt_stall + 1'b1;
      if (w_redirect && (r_cnt_flush != {CNT_W{1'b1}}))
        r_cnt_flush <= r_cnt_flush + 1'b1;
    end
  end

  assign hif.stall_pc    = rstn & w_stall_pc;
  assign hif.stall_ifid  = rstn & w_stall_ifid;
  assign hif.stall_idex  = rstn & w_stall_idex;
  assign hif.stall_exmem = rstn & w_stall_exmem;
  assign hif.flush_ifid  = rstn & w_flush_ifid;
  assign hif.flush_idex  = rstn & w_flush_idex;
  assign hif.flush_memwb = rstn & w_flush_memwb;
  assign hif.redirect    = rstn & w_redirect;
  assign hif.halted      = rstn & w_halted;
  assign hif.fwd_a       = {2{rstn}} & w_fwd_a;
  assign hif.fwd_b       = {2{rstn}} & w_fwd_b;
  assign hif.mem_err     = r_mem_err;
  assign hif.cnt_stall   = r_cnt_stall;
  assign hif.cnt_flush   = r_cnt_flush;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched with MEM_TIMEOUT=4, CNT_W=4; expected values hand-derived per step.
module tb_hazard_sched;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  hazard_sched_if #(.CNT_W(4)) hif();

  hazard_sched #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .hif  (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hif.id_rs1 = 5'd0;     hif.id_rs2 = 5'd0;
    hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
    hif.ex_rs1 = 5'd0;     hif.ex_rs2 = 5'd0;   hif.ex_rd = 5'd0;
    hif.ex_regwrite = 1'b0; hif.ex_wdsel = 2'b00;
    hif.ex_npcop = 3'b000; hif.ex_br_taken = 1'b0;
    hif.mem_rd = 5'd0;     hif.mem_regwrite = 1'b0;
    hif.wb_rd = 5'd0;      hif.wb_regwrite = 1'b0;
    hif.dmem_req = 1'b0;   hif.dmem_ready = 1'b0;
  endtask

  task automatic rst_pulse();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    clr();
    // Hazards present while in reset: every output must still be 0.
    hif.dmem_req = 1'b1; hif.ex_npcop = 3'b010;
    hif.mem_regwrite = 1'b1; hif.mem_rd = 5'd3; hif.ex_rs1 = 5'd3;
    #3;
    chk("rst_stall_pc", hif.stall_pc, 0);
    chk("rst_flush_memwb", hif.flush_memwb, 0);
    chk("rst_redirect", hif.redirect, 0);
    chk("rst_fwd_a", hif.fwd_a, 0);
    chk("rst_cnt_stall", hif.cnt_stall, 0);
    chk("rst_mem_err", hif.mem_err, 0);
    tick(); tick();
    clr();
    rstn = 1'b1;
    #1;
    chk("idle_stall_pc", hif.stall_pc, 0);

    // Load-use: lw x5 in EX, add reading x5 in ID.
    hif.ex_rd = 5'd5; hif.ex_wdsel = 2'b01; hif.ex_regwrite = 1'b1;
    hif.id_use_rs1 = 1'b1; hif.id_rs1 = 5'd5;
    #1;
    chk("lu_stall_pc", hif.stall_pc, 1);
    chk("lu_stall_ifid", hif.stall_ifid, 1);
    chk("lu_flush_idex", hif.flush_idex, 1);
    chk("lu_stall_idex", hif.stall_idex, 0);
    chk("lu_redirect", hif.redirect, 0);
    tick();
    clr();
    hif.mem_rd = 5'd5; hif.mem_regwrite = 1'b1; hif.ex_rs1 = 5'd5;
    hif.id_use_rs1 = 1'b1; hif.id_rs1 = 5'd5;
    #1;
    chk("lu_next_stall_pc", hif.stall_pc, 0);
    chk("lu_next_fwd_a", hif.fwd_a, 2'b01);
    chk("lu_cnt_stall", hif.cnt_stall, 1);
    tick();
    chk("lu_cnt_stall_hold", hif.cnt_stall, 1);

    // x0 load never stalls; forwarding priority MEM over WB.
    clr();
    hif.ex_rd = 5'd0; hif.ex_wdsel = 2'b01; hif.ex_regwrite = 1'b1;
    hif.id_use_rs1 = 1'b1; hif.id_rs1 = 5'd0;
    hif.mem_rd = 5'd7; hif.mem_regwrite = 1'b1;
    hif.wb_rd = 5'd7; hif.wb_regwrite = 1'b1;
    hif.ex_rs2 = 5'd7; hif.ex_rs1 = 5'd3;
    #1;
    chk("x0_no_stall", hif.stall_pc, 0);
    chk("fwd_b_mem", hif.fwd_b, 2'b01);
    chk("fwd_a_none", hif.fwd_a, 2'b00);
    hif.mem_regwrite = 1'b0;
    #1;
    chk("fwd_b_wb", hif.fwd_b, 2'b10);
    hif.wb_rd = 5'd0; hif.wb_regwrite = 1'b1; hif.ex_rs2 = 5'd0;
    #1;
    chk("fwd_b_x0", hif.fwd_b, 2'b00);
    tick();

    // Branches.
    clr();
    hif.ex_npcop = 3'b001; hif.ex_br_taken = 1'b0;
    #1;
    chk("br_nt_redirect", hif.redirect, 0);
    chk("br_nt_flush_ifid", hif.flush_ifid, 0);
    hif.ex_br_taken = 1'b1;
    #1;
    chk("br_t_redirect", hif.redirect, 1);
    chk("br_t_flush_ifid", hif.flush_ifid, 1);
    chk("br_t_flush_idex", hif.flush_idex, 1);
    tick();
    chk("br_cnt_flush1", hif.cnt_flush, 1);
    clr();
    hif.ex_npcop = 3'b100;
    hif.ex_rd = 5'd9; hif.ex_wdsel = 2'b01; hif.ex_regwrite = 1'b1;
    hif.id_use_rs2 = 1'b1; hif.id_rs2 = 5'd9;
    #1;
    chk("jmp_lu_redirect", hif.redirect, 1);
    chk("jmp_lu_stall_pc", hif.stall_pc, 0);
    tick();
    chk("jmp_cnt_flush2", hif.cnt_flush, 2);
    chk("jmp_cnt_stall", hif.cnt_stall, 1);

    // Memory wait: 3 frozen cycles, release on the 4th with a pending jump.
    clr();
    rst_pulse();
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    #1;
    chk("mw1_stall_exmem", hif.stall_exmem, 1);
    chk("mw1_flush_memwb", hif.flush_memwb, 1);
    tick();
    hif.ex_npcop = 3'b010;
    #1;
    chk("mw2_stall_pc", hif.stall_pc, 1);
    chk("mw2_redirect", hif.redirect, 0);
    tick();
    #1;
    chk("mw3_stall_idex", hif.stall_idex, 1);
    chk("mw3_redirect", hif.redirect, 0);
    tick();
    chk("mw_cnt_stall3", hif.cnt_stall, 3);
    hif.dmem_ready = 1'b1;
    #1;
    chk("mw_rel_stall_pc", hif.stall_pc, 0);
    chk("mw_rel_flush_memwb", hif.flush_memwb, 0);
    chk("mw_rel_redirect", hif.redirect, 1);
    tick();
    clr();
    #1;
    chk("mw_after_cnt_stall", hif.cnt_stall, 3);
    chk("mw_after_cnt_flush", hif.cnt_flush, 1);
    chk("mw_after_stall_pc", hif.stall_pc, 0);

    // Timeout at the 4th wait cycle, then HALT until reset.
    rst_pulse();
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("to_c4_mem_err", hif.mem_err, 0);
    chk("to_c4_halted", hif.halted, 0);
    tick();
    hif.dmem_ready = 1'b1; hif.ex_npcop = 3'b010;
    #1;
    chk("to_mem_err_pulse", hif.mem_err, 1);
    chk("to_halted", hif.halted, 1);
    chk("to_halt_stall_pc", hif.stall_pc, 1);
    chk("to_halt_flush_memwb", hif.flush_memwb, 1);
    chk("to_halt_redirect", hif.redirect, 0);
    tick();
    chk("to_mem_err_drop", hif.mem_err, 0);
    chk("to_halted_hold", hif.halted, 1);
    chk("to_cnt_stall5", hif.cnt_stall, 5);
    rstn = 1'b0;
    #1;
    chk("halt_rst_halted", hif.halted, 0);
    chk("halt_rst_stall_pc", hif.stall_pc, 0);
    chk("halt_rst_cnt_stall", hif.cnt_stall, 0);
    clr();
    rstn = 1'b1;
    #1;
    chk("halt_rst_run", hif.halted, 0);
    tick();
    chk("halt_rst_run_stall", hif.stall_pc, 0);

    // Saturation: HALT stalls every cycle; 4-bit counter sticks at 15.
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_cnt10", hif.cnt_stall, 10);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_cnt20", hif.cnt_stall, 15);
    chk("sat_halted", hif.halted, 1);

    clr();
    rst_pulse();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
